// File: rtl/user_credit_sched_rd_pkg.sv
// Shared host-interface types and constants used by the user read bypass path.
package lynxTypes;

    localparam int LEN_BITS      = 28;
    localparam int AXI_DATA_BITS = 512;
    localparam int N_OUTSTANDING = 8;
    localparam int VADDR_BITS    = 48;
    localparam int DEST_BITS     = 4;
    localparam int PID_BITS      = 6;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic                  ctl;
        logic [DEST_BITS-1:0]  dest;
        logic [PID_BITS-1:0]   pid;
        logic                  host;
    } req_t;

    typedef enum logic {
        ST_ARB,
        ST_SEND
    } sched_st_e;

endpackage

// File: rtl/user_credit_sched_rd_if.sv
// Generic valid/ready metadata channel; W is the payload width in bits.
interface metaIntf #(
    parameter int W = 1
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/user_credit_sched_rd_queue.sv
// Synchronous FIFO holding the {cpid, beats-1} issue order for the read-data mux.
module user_sched_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // A same-cycle pop frees a slot, so a push into a full queue still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q + AW'(do_push);
        rptr_d = rptr_q + AW'(do_pop);
        cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/user_credit_sched_rd.sv
// Credit-limited round-robin scheduler: per-cpid read requests onto one host
// request channel, with the issue order published for the read-data mux.
module user_credit_sched_rd #(
    parameter int N_CPID        = 2,
    parameter int N_OUTSTANDING = lynxTypes::N_OUTSTANDING,
    parameter int MUX_DEPTH     = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    metaIntf.s                s_req [N_CPID],
    metaIntf.m                m_req,
    metaIntf.m                mux,
    input  logic [N_CPID-1:0] rxfer
);
    import lynxTypes::*;

    localparam int N_CPID_BITS   = (N_CPID > 1) ? $clog2(N_CPID) : 1;
    localparam int CRED_W        = $clog2(N_OUTSTANDING) + 1;
    localparam int BEAT_LOG_BITS = $clog2(AXI_DATA_BITS / 8);
    localparam int BLEN_BITS     = LEN_BITS - BEAT_LOG_BITS;
    localparam int MUX_W         = N_CPID_BITS + BLEN_BITS;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(N_OUTSTANDING);

    sched_st_e                       state_q;
    logic [N_CPID_BITS-1:0]          rr_q, rr_nxt, gnt, idx;
    logic [N_CPID-1:0][CRED_W-1:0]   cred_q, cred_d;
    logic                            m_vld_q;
    req_t                            m_data_q;
    logic [N_CPID-1:0]               s_valid, elig, grant_oh;
    req_t                            s_data [N_CPID];
    logic                            any, take;
    logic [BLEN_BITS-1:0]            beats, blen_m1;
    logic                            q_full, q_empty;
    logic [MUX_W-1:0]                q_rdata;
    logic [$clog2(MUX_DEPTH):0]      q_count;
    logic                            cnt_unused;

    for (genvar gi = 0; gi < N_CPID; gi++) begin : g_cpid
        assign s_valid[gi]     = s_req[gi].valid;
        assign s_data[gi]      = req_t'(s_req[gi].data);
        assign s_req[gi].ready = grant_oh[gi];
        assign elig[gi]        = s_valid[gi] && (cred_q[gi] != '0) && !q_full;
    end

    // First eligible cpid at or after the round-robin pointer.
    always_comb begin
        any = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 0; k < N_CPID; k++) begin
            idx = N_CPID_BITS'((int'(rr_q) + k) % N_CPID);
            if (!any && elig[idx]) begin
                any = 1'b1;
                gnt = idx;
            end
        end
    end

    assign take   = (state_q == ST_ARB) && any;
    assign rr_nxt = (int'(gnt) == N_CPID - 1) ? '0 : gnt + 1'b1;

    always_comb begin
        grant_oh = '0;
        if (take) grant_oh[gnt] = 1'b1;
    end

    // len==0 rounds to zero beats; it is still a one-beat transfer, field 0.
    assign beats   = BLEN_BITS'(({1'b0, s_data[gnt].len}
                                 + (LEN_BITS+1)'(2**BEAT_LOG_BITS - 1)) >> BEAT_LOG_BITS);
    assign blen_m1 = (beats == '0) ? '0 : beats - 1'b1;

    always_comb begin
        cred_d = cred_q;
        for (int i = 0; i < N_CPID; i++) begin
            if (grant_oh[i] && !rxfer[i])
                cred_d[i] = cred_q[i] - 1'b1;
            else if (rxfer[i] && !grant_oh[i] && cred_q[i] != CRED_MAX)
                cred_d[i] = cred_q[i] + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CPID; i++) cred_q[i] <= CRED_MAX;
        end else begin
            cred_q <= cred_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_ARB;
            rr_q     <= '0;
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
        end else begin
            case (state_q)
                ST_ARB: if (any) begin
                    m_data_q <= s_data[gnt];
                    m_vld_q  <= 1'b1;
                    rr_q     <= rr_nxt;
                    state_q  <= ST_SEND;
                end
                ST_SEND: if (m_req.ready) begin
                    m_vld_q <= 1'b0;
                    state_q <= ST_ARB;
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    assign m_req.valid = m_vld_q;
    assign m_req.data  = m_data_q;

    user_sched_queue #(
        .W     (MUX_W),
        .DEPTH (MUX_DEPTH)
    ) u_queue (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (take),
        .wdata_i ({gnt, blen_m1}),
        .pop_i   (mux.ready && !q_empty),
        .rdata_o (q_rdata),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign mux.valid  = !q_empty;
    assign mux.data   = q_rdata;
    assign cnt_unused = ^q_count;

endmodule

// File: tb/tb_user_credit_sched_rd.sv
// Randomised and directed bench for user_credit_sched_rd against a queue-based model.
module tb_user_credit_sched_rd;
    import lynxTypes::*;

    localparam int N    = 2;
    localparam int MD   = 16;
    localparam int NO   = 8;
    localparam int BLOG = $clog2(AXI_DATA_BITS / 8);
    localparam int BLB  = LEN_BITS - BLOG;
    localparam int MW   = 1 + BLB;
    localparam int RW   = $bits(req_t);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [N-1:0]  rxfer, tv, tr;
    req_t          td [N];
    logic          m_ready, mux_ready;

    metaIntf #(.W(RW)) s_req [N] ();
    metaIntf #(.W(RW)) m_req ();
    metaIntf #(.W(MW)) mux ();

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign s_req[g].valid = tv[g];
        assign s_req[g].data  = td[g];
        assign tr[g]          = s_req[g].ready;
    end
    assign m_req.ready = m_ready;
    assign mux.ready   = mux_ready;

    user_credit_sched_rd #(.N_CPID(N), .N_OUTSTANDING(NO), .MUX_DEPTH(MD)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_req(s_req), .m_req(m_req), .mux(mux), .rxfer(rxfer)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int               mcred [N];
    int               mrr, eg, c;
    bit               mbusy;
    req_t             mheld;
    logic [MW-1:0]    mq [$];
    logic [N-1:0]     exp_rdy;

    function automatic logic [MW-1:0] mux_word(int cp, logic [LEN_BITS-1:0] len);
        longint b;
        b = (longint'(len) + (longint'(1) << BLOG) - 1) / (longint'(1) << BLOG);
        b = b % (longint'(1) << BLB);
        if (b == 0) b = 1;
        return MW'((longint'(cp) << BLB) | (b - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mcred[i] = NO;
        mrr = 0;
        mbusy = 0;
        mq.delete();
    endtask

    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin model_reset(); continue; end
        eg = -1;
        if (!mbusy)
            for (int k = 0; k < N; k++) begin
                c = (mrr + k) % N;
                if (eg < 0 && tv[c] && mcred[c] > 0 && mq.size() < MD) eg = c;
            end
        exp_rdy = '0;
        if (eg >= 0) exp_rdy[eg] = 1'b1;
        chk("s_ready", tr, exp_rdy);
        chk("m_valid", m_req.valid, mbusy);
        if (mbusy) chk("m_data", m_req.data, mheld);
        chk("mux_valid", mux.valid, mq.size() != 0);
        if (mq.size() != 0) chk("mux_data", mux.data, mq[0]);
        @(posedge aclk);
        if (!aresetn) begin model_reset(); continue; end
        if (mq.size() > 0 && mux_ready) void'(mq.pop_front());
        if (eg >= 0) begin
            mq.push_back(mux_word(eg, td[eg].len));
            mheld = td[eg];
            mbusy = 1;
            mrr = (eg + 1) % N;
        end else if (mbusy && m_ready) mbusy = 0;
        for (int i = 0; i < N; i++) begin
            if (eg == i && rxfer[i]) ;
            else if (eg == i) mcred[i]--;
            else if (rxfer[i] && mcred[i] < NO) mcred[i]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic req_t mkreq(logic [LEN_BITS-1:0] len);
        logic [RW-1:0] raw;
        req_t r;
        raw = RW'({$urandom(), $urandom(), $urandom()});
        r = raw;
        r.len = len;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge aclk);
        #1 aresetn = 1'b0;
        tv = '0; rxfer = '0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        g = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            if (|tr) begin g = tr; return; end
            step();
        end
    endtask

    task automatic count_grants(input int cp, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge aclk);
            if (tr[cp]) cnt++;
            step();
        end
    endtask

    initial begin
        req_t          r0;
        logic [MW-1:0] e;
        logic [N-1:0]  g;
        int            cnt;

        tv = '0; rxfer = '0; m_ready = 1'b0; mux_ready = 1'b0;
        for (int i = 0; i < N; i++) td[i] = '0;
        repeat (2) @(negedge aclk);
        chk("rst_m_valid", m_req.valid, 0);
        chk("rst_mux_valid", mux.valid, 0);
        chk("rst_ready", tr, 0);
        step();
        aresetn = 1'b1;

        // single cpid0 request, len=256 -> 4 beats
        step();
        m_ready = 1'b1;
        r0 = mkreq(28'd256);
        td[0] = r0; tv[0] = 1'b1;
        @(negedge aclk);
        chk("t1_grant", tr, 2'b01);
        step();
        tv = '0;
        @(negedge aclk);
        chk("t1_mdata", m_req.data, r0);
        e = MW'(3);
        chk("t1_mux", mux.data, e);
        chk("t1_cred_model", mcred[0], 7);
        step();
        rxfer = 2'b01;
        step();
        rxfer = '0;
        chk("t1_cred_back", mcred[0], 8);
        mux_ready = 1'b1;
        repeat (3) step();

        // both cpids continuously: alternate starting at cpid1 (rr advanced)
        td[0] = mkreq(LEN_BITS'($urandom_range(0, 4096)));
        td[1] = mkreq(LEN_BITS'($urandom_range(0, 4096)));
        tv = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            chk($sformatf("t2_gnt%0d", k), tr, (k % 2) ? 2'b00 : (((k / 2) % 2) ? 2'b01 : 2'b10));
            step();
        end
        tv = '0;

        // credit exhaustion on cpid0
        do_reset();
        td[0] = mkreq(LEN_BITS'($urandom_range(0, 4096)));
        tv = 2'b01;
        count_grants(0, 40, cnt);
        chk("t3_grants", cnt, 8);
        chk("t3_cred_model", mcred[0], 0);
        tv = 2'b11;
        td[1] = mkreq(28'd100);
        wait_grant(g);
        chk("t3_cpid1", g, 2'b10);
        step();
        tv = 2'b01; rxfer = 2'b01;
        step();
        rxfer = '0;
        count_grants(0, 12, cnt);
        chk("t3_one_more", cnt, 1);
        tv = '0;

        // queue full with mux stalled
        do_reset();
        mux_ready = 1'b0; rxfer = 2'b11; tv = 2'b11;
        count_grants(0, 64, cnt);
        chk("t4_model_q", mq.size(), 16);
        @(negedge aclk);
        chk("t4_full_block", tr, 0);
        step();
        mux_ready = 1'b1;
        @(negedge aclk);
        chk("t4_pop_cycle", tr, 0);
        step();
        mux_ready = 1'b0;
        @(negedge aclk);
        chk("t4_after_pop", tr, 2'b01);
        step();
        tv = '0; rxfer = '0; mux_ready = 1'b1;
        repeat (20) step();

        // beat-field edges and credit corner cases
        do_reset();
        mux_ready = 1'b0;
        td[0] = mkreq(28'd0);
        tv = 2'b01; rxfer = 2'b01;
        @(negedge aclk);
        chk("t5_grant", tr, 2'b01);
        step();
        tv = '0;
        @(negedge aclk);
        chk("t5_len0", mux.data, MW'(0));
        chk("t5_cred_coinc", mcred[0], 8);
        step();
        rxfer = '0;
        chk("t5_cred_sat", mcred[0], 8);
        mux_ready = 1'b1;
        step();
        mux_ready = 1'b0;
        td[1] = mkreq(28'd65);
        tv = 2'b10;
        wait_grant(g);
        chk("t5_g1", g, 2'b10);
        step();
        tv = '0;
        @(negedge aclk);
        e = '0; e[MW-1] = 1'b1; e[0] = 1'b1;
        chk("t5_len65", mux.data, e);
        step();
        mux_ready = 1'b1; tv = 2'b01;
        count_grants(0, 40, cnt);
        chk("t5_cred_total", cnt, 8);
        tv = '0;

        // reset while a request is stalled in send
        do_reset();
        m_ready = 1'b0; mux_ready = 1'b0; tv = 2'b01;
        wait_grant(g);
        step();
        tv = '0;
        @(negedge aclk);
        chk("t6_pending", m_req.valid, 1);
        #1 aresetn = 1'b0;
        #1;
        chk("t6_mvalid_rst", m_req.valid, 0);
        chk("t6_mux_rst", mux.valid, 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        m_ready = 1'b1; tv = 2'b11;
        @(negedge aclk);
        chk("t6_rr0", tr, 2'b01);
        step();
        tv = '0;

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                tv[i]    = ($urandom_range(0, 3) != 0);
                rxfer[i] = ($urandom_range(0, 3) == 0);
                td[i]    = ($urandom_range(0, 7) == 0) ? mkreq(LEN_BITS'($urandom()))
                                                       : mkreq(LEN_BITS'($urandom_range(0, 2048)));
            end
            m_ready   = $urandom_range(0, 1);
            mux_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        tv = '0; rxfer = '0;
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
